// File: rtl/cordic_vectoring_if.sv
`default_nettype none
// ============================================================================
// Module   : cordic_vectoring_if
// Brief    : Custom-instruction handshake and data bus for cordic_vectoring.
//            The master side issues start/operands; the slave side returns
//            the angle, magnitude and a one-cycle done pulse.
// Revision : 1.0  initial release
// ============================================================================
interface cordic_vectoring_if #(
  parameter int DATA_WIDTH = 22
);
  logic                  clk_en;
  logic                  start;
  logic [DATA_WIDTH-1:0] dataa;
  logic [DATA_WIDTH-1:0] datab;
  logic [31:0]           result;
  logic [DATA_WIDTH-1:0] mag;
  logic                  done;

  modport master (
    output clk_en, start, dataa, datab,
    input  result, mag, done
  );

  modport slave (
    input  clk_en, start, dataa, datab,
    output result, mag, done
  );
endinterface
`default_nettype wire

// File: rtl/cordic_vectoring.sv
`default_nettype none
// ============================================================================
// Module   : cordic_vectoring
// Brief    : Iterative vectoring-mode CORDIC. Drives y to zero and returns
//            atan2(y, x) (signed Q3.20, sign-extended to 32 bits) and the
//            vector magnitude (Q2.20). Start/done multicycle handshake.
//            Optional macro CORDIC_VEC_GAIN_COMP_EN scales the magnitude by
//            1/K so it equals the true magnitude; otherwise the raw x (K*|v|)
//            is returned and no multiplier is built.
// Revision : 1.0  initial release
// ============================================================================
module cordic_vectoring #(
  parameter int INTEGER_WIDTH        = 2,
  parameter int DECIMAL_WIDTH        = 20,
  parameter int DATA_WIDTH           = INTEGER_WIDTH + DECIMAL_WIDTH,
  parameter int ITERATIONS           = 16,
  parameter int CORDIC_COUNTER_WIDTH = 4
) (
  input wire logic          clk,
  input wire logic          reset,
  cordic_vectoring_if.slave bus
);
  // x/y carry one guard bit for the CORDIC gain; z is Q3.20 to reach +/-pi.
  localparam int XY_WIDTH = DATA_WIDTH + 1;
  localparam int Z_WIDTH  = INTEGER_WIDTH + DECIMAL_WIDTH + 1;
  localparam logic [CORDIC_COUNTER_WIDTH-1:0] LAST_COUNT =
    CORDIC_COUNTER_WIDTH'(ITERATIONS - 1);

  localparam logic signed [Z_WIDTH-1:0] HALF_PI = Z_WIDTH'(1647099);

  // atan(2^-i) in Q2.20, shared with the rotation stages.
  localparam logic signed [Z_WIDTH-1:0] ATAN_LUT [16] = '{
    Z_WIDTH'(823550), Z_WIDTH'(486171), Z_WIDTH'(256879), Z_WIDTH'(130396),
    Z_WIDTH'(65451),  Z_WIDTH'(32757),  Z_WIDTH'(16383),  Z_WIDTH'(8192),
    Z_WIDTH'(4096),   Z_WIDTH'(2048),   Z_WIDTH'(1024),   Z_WIDTH'(512),
    Z_WIDTH'(256),    Z_WIDTH'(128),    Z_WIDTH'(64),     Z_WIDTH'(32)
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PREROT = 2'd1,
    ITER   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                          state;
  state_t                          state_next;
  logic signed [XY_WIDTH-1:0]      x;
  logic signed [XY_WIDTH-1:0]      y;
  logic signed [Z_WIDTH-1:0]       z;
  logic [CORDIC_COUNTER_WIDTH-1:0] count;
  logic                            zero;
  logic [31:0]                     result_q;
  logic [DATA_WIDTH-1:0]           mag_q;
  logic                            done_q;

  logic signed [XY_WIDTH-1:0]      x_shift;
  logic signed [XY_WIDTH-1:0]      y_shift;
  logic [DATA_WIDTH-1:0]           mag_final;

  assign x_shift = x >>> count;
  assign y_shift = y >>> count;

`ifdef CORDIC_VEC_GAIN_COMP_EN
  // 1/K = 0.607253 as Q0.20; product is Q*.40, keep the Q2.20 slice.
  localparam logic signed [Z_WIDTH-1:0] INV_GAIN = Z_WIDTH'(32'h09B74E);
  logic signed [XY_WIDTH+Z_WIDTH-1:0] mag_product;
  assign mag_product = x * INV_GAIN;
  assign mag_final   = mag_product[DECIMAL_WIDTH +: DATA_WIDTH];
`else
  assign mag_final = x[DATA_WIDTH-1:0];
`endif

  assign bus.result = result_q;
  assign bus.mag    = mag_q;
  assign bus.done   = done_q;

  // State register; frozen while clk_en is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else if (bus.clk_en) begin
      state <= state_next;
    end
  end

  // Next-state logic: fixed-length walk IDLE -> PREROT -> ITER* -> DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = PREROT;
      PREROT:  state_next = ITER;
      ITER:    if (count == LAST_COUNT) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath, counter and output registers. done is a pulse, so it drops
  // back to 0 even on a frozen cycle rather than stretching.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x        <= '0;
      y        <= '0;
      z        <= '0;
      count    <= '0;
      zero     <= 1'b0;
      result_q <= '0;
      mag_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.clk_en) begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              x <= {bus.dataa[DATA_WIDTH-1], bus.dataa};
              y <= {bus.datab[DATA_WIDTH-1], bus.datab};
            end
          end
          PREROT: begin
            // Fold the left half-plane into the right so iterations converge.
            if (x < 0 && y >= 0) begin
              x <= y;
              y <= -x;
              z <= HALF_PI;
            end else if (x < 0) begin
              x <= -y;
              y <= x;
              z <= -HALF_PI;
            end else begin
              z <= '0;
            end
            zero  <= (x == '0) && (y == '0);
            count <= '0;
          end
          ITER: begin
            if (y >= 0) begin
              x <= x + y_shift;
              y <= y - x_shift;
              z <= z + ATAN_LUT[count];
            end else begin
              x <= x - y_shift;
              y <= y + x_shift;
              z <= z - ATAN_LUT[count];
            end
            count <= count + 1'b1;
          end
          DONE: begin
            if (zero) begin
              result_q <= '0;
              mag_q    <= '0;
            end else begin
              result_q <= {{(32-Z_WIDTH){z[Z_WIDTH-1]}}, z};
              mag_q    <= mag_final;
            end
            done_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule
`default_nettype wire
